// File: rtl/dac_feeder_pkg.sv
// dac_feeder_pkg: shared DAC constants and feeder state encoding.
package dac_feeder_pkg;
    localparam int SAMPLE_W = 16;
    localparam logic [SAMPLE_W-1:0] MUTE_VAL = 16'h0000;
    typedef enum logic {MUTE, RUN} state_t;
endpackage

// File: rtl/dac_feeder_fifo_mem.sv
// dac_fifo_mem: stereo-pair dual-port RAM, synchronous write, asynchronous read.
module dac_fifo_mem #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [31:0]           wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [31:0]           rdata
);
    logic [31:0] mem [2**DEPTH_LOG2];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/dac_feeder.sv
// dac_feeder: stereo sample FIFO feeding a DAC serializer, muting until primed.
module dac_feeder
    import dac_feeder_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int PRIME      = 8,
    parameter int LOW_MARK   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [SAMPLE_W-1:0]   wr_l,
    input  logic [SAMPLE_W-1:0]   wr_r,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   level,
    input  logic                  irq_en,
    output logic                  refill_irq,
    output logic                  underrun,
    input  logic                  underrun_clr,
    input  logic                  next,
    output logic [SAMPLE_W-1:0]   sample_l,
    output logic [SAMPLE_W-1:0]   sample_r
);
    localparam int LW = DEPTH_LOG2 + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(2**DEPTH_LOG2);
    localparam logic [LW-1:0] PRIME_L = LW'(PRIME);
    localparam logic [LW-1:0] LOW_L   = LW'(LOW_MARK);
    state_t                state;
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [31:0]           rdata;
    logic                  push, pop, starve;
    always_comb begin
        full       = level == DEPTH_L;
        push       = wr_en && !full;
        starve     = state == RUN && next && level == '0;
        pop        = state == RUN && next && level != '0;
        refill_irq = irq_en && state == RUN && level <= LOW_L;
    end
    dac_fifo_mem #(.DEPTH_LOG2(DEPTH_LOG2)) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata ({wr_l, wr_r}),
        .raddr (rd_ptr),
        .rdata (rdata)
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= MUTE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            sample_l <= MUTE_VAL;
            sample_r <= MUTE_VAL;
            underrun <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            if (pop) rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            level <= level + LW'(push) - LW'(pop);
            // every next reloads the outputs; only a real pop carries data
            if (next) begin
                sample_l <= pop ? rdata[31:16] : MUTE_VAL;
                sample_r <= pop ? rdata[15:0] : MUTE_VAL;
            end
            if (state == MUTE && level >= PRIME_L) state <= RUN;
            else if (starve) state <= MUTE;
            underrun <= starve || (underrun && !underrun_clr);
        end
    end
endmodule

// File: tb/tb_dac_feeder.sv
// tb_dac_feeder: directed and random checks of dac_feeder against a queue model.
module tb_dac_feeder;
    import dac_feeder_pkg::*;
    logic        clk = 1'b0, reset = 1'b1;
    logic        wr_en = 1'b0, irq_en = 1'b0, underrun_clr = 1'b0, next = 1'b0;
    logic [15:0] wr_l = '0, wr_r = '0;
    logic        full, refill_irq, underrun;
    logic [4:0]  level;
    logic [15:0] sample_l, sample_r;
    int          checks = 0, errors = 0;
    logic [31:0] q[$];
    logic        m_run = 1'b0, m_under = 1'b0;
    logic [15:0] exp_l = '0, exp_r = '0;

    dac_feeder dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_l(wr_l), .wr_r(wr_r),
        .full(full), .level(level), .irq_en(irq_en), .refill_irq(refill_irq),
        .underrun(underrun), .underrun_clr(underrun_clr), .next(next),
        .sample_l(sample_l), .sample_r(sample_r)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".level"}, 32'(level), 32'(q.size()));
        check({tag, ".full"}, 32'(full), 32'(q.size() == 16));
        check({tag, ".sample_l"}, 32'(sample_l), 32'(exp_l));
        check({tag, ".sample_r"}, 32'(sample_r), 32'(exp_r));
        check({tag, ".underrun"}, 32'(underrun), 32'(m_under));
        check({tag, ".refill_irq"}, 32'(refill_irq), 32'(irq_en && m_run && q.size() <= 4));
        check({tag, ".state"}, 32'(dut.state), 32'(m_run ? RUN : MUTE));
    endtask

    // one clock: apply inputs, advance the model on the edge, then compare
    task automatic step(input string tag, input logic we, input logic [15:0] l, input logic [15:0] r,
                        input logic nx, input logic clr, input logic ie);
        int  sz;
        logic set;
        wr_en = we; wr_l = l; wr_r = r; next = nx; underrun_clr = clr; irq_en = ie;
        @(posedge clk);
        sz  = q.size();
        set = nx && m_run && sz == 0;
        if (nx) begin
            if (m_run && sz > 0) {exp_l, exp_r} = q.pop_front();
            else begin exp_l = '0; exp_r = '0; end
        end
        if (set) m_under = 1'b1;
        else if (clr) m_under = 1'b0;
        if (!m_run && sz >= 8) m_run = 1'b1;
        else if (set) m_run = 1'b0;
        if (we && sz < 16) q.push_back({l, r});
        #1 check_all(tag);
    endtask

    task automatic model_clear();
        q.delete(); m_run = 1'b0; m_under = 1'b0; exp_l = '0; exp_r = '0;
    endtask

    task automatic do_reset();
        wr_en = 0; next = 0; underrun_clr = 0; irq_en = 0;
        reset = 1'b1;
        model_clear();
        @(negedge clk) reset = 1'b0;
        check_all("reset");
    endtask

    initial begin
        do_reset();
        // ordered playback of 8 primed pairs
        for (int i = 0; i < 8; i++) step("prime8", 1, 16'h0FF0 + 16'(i), 16'hAA55 - 16'(i), 0, 0, 0);
        step("prime_idle", 0, 0, 0, 0, 0, 0);
        check("run_after_prime", 32'(dut.state), 32'(RUN));
        for (int i = 0; i < 8; i++) begin
            step("play", 0, 0, 0, 1, 0, 0);
            check("play_l", 32'(sample_l), 32'(16'h0FF0 + 16'(i)));
            check("play_r", 32'(sample_r), 32'(16'hAA55 - 16'(i)));
        end
        check("drained", 32'(level), 32'd0);
        // push and next together on an empty RUN fifo
        step("push_empty_pop", 1, 16'h1234, 16'h5678, 1, 0, 0);
        check("epop_level", 32'(level), 32'd1);
        check("epop_mute", 32'(sample_l), 32'd0);
        step("epop_clr", 0, 0, 0, 0, 1, 0);
        // under-primed: next is ignored
        do_reset();
        for (int i = 0; i < 7; i++) step("push7", 1, 16'($urandom), 16'($urandom), 0, 0, 0);
        for (int i = 0; i < 3; i++) step("muted_next", 0, 0, 0, 1, 0, 0);
        check("muted_level", 32'(level), 32'd7);
        // ninth next underruns
        do_reset();
        for (int i = 0; i < 8; i++) step("prime", 1, 16'($urandom), 16'($urandom), 0, 0, 0);
        step("idle", 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) step("drain9", 0, 0, 0, 1, 0, 0);
        check("underrun_set", 32'(underrun), 32'd1);
        step("clr_hold", 0, 0, 0, 0, 0, 0);
        step("clr", 0, 0, 0, 0, 1, 0);
        check("underrun_clr", 32'(underrun), 32'd0);
        // full fifo drops a push even with a concurrent pop
        do_reset();
        for (int i = 0; i < 16; i++) step("fill", 1, 16'($urandom), 16'($urandom), 0, 0, 0);
        check("full", 32'(full), 32'd1);
        step("push17_pop", 1, 16'hDEAD, 16'hBEEF, 1, 0, 0);
        check("after17_level", 32'(level), 32'd15);
        // refill irq as level falls to the low mark
        do_reset();
        for (int i = 0; i < 8; i++) step("prime", 1, 16'($urandom), 16'($urandom), 0, 0, 1);
        step("idle", 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step("irq_drain", 0, 0, 0, 1, 0, 1);
        check("irq_high", 32'(refill_irq), 32'd1);
        step("irq_off", 0, 0, 0, 0, 0, 0);
        check("irq_low", 32'(refill_irq), 32'd0);
        // asynchronous reset mid-drain
        do_reset();
        for (int i = 0; i < 8; i++) step("prime", 1, 16'($urandom), 16'($urandom), 0, 0, 0);
        step("idle", 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step("drain_to5", 0, 0, 0, 1, 0, 0);
        check("at5", 32'(level), 32'd5);
        next = 0;
        #3 reset = 1'b1;
        model_clear();
        #1 check_all("async_reset");
        @(negedge clk) reset = 1'b0;
        for (int i = 0; i < 3; i++) step("post_reset_next", 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 8; i++) step("reprime", 1, 16'($urandom), 16'($urandom), 0, 0, 0);
        step("idle", 0, 0, 0, 0, 0, 0);
        step("reprime_play", 0, 0, 0, 1, 0, 0);
        // random traffic
        for (int i = 0; i < 500; i++)
            step("rand", $urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom),
                 $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0, 1'($urandom));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
